// File: rtl/cp0_regfile_pkg.sv
// ---------------------------------------------------------------------------
// cp0_regfile_pkg
// Shared definitions for the CP0 register file: the exception kinds reported
// by commit, CP0 register numbers, ExcCode values, MTC0 write masks and the
// constant/reset register values.
// ---------------------------------------------------------------------------
package cp0_regfile_pkg;

   typedef enum logic [2:0] {
      ExcInterrupt,
      ExcAdEL,
      ExcAdES,
      ExcSysCall,
      ExcBreak,
      ExcReservedInst,
      ExcOverflow,
      ExcEret
   } ExceptionType;

   // CP0 register numbers (select is always 0)
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_PRID     = 5'd15;
   localparam logic [4:0] CP0_CONFIG   = 5'd16;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_CODE_INT  = 5'h00;
   localparam logic [4:0] EXC_CODE_ADEL = 5'h04;
   localparam logic [4:0] EXC_CODE_ADES = 5'h05;
   localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
   localparam logic [4:0] EXC_CODE_BP   = 5'h09;
   localparam logic [4:0] EXC_CODE_RI   = 5'h0A;
   localparam logic [4:0] EXC_CODE_OV   = 5'h0C;

   // Software-writable bits: Status.IM[15:8], EXL[1], IE[0]; Cause.IP[9:8]
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
   localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
   localparam logic [31:0] CONFIG_VALUE = 32'h8000_0000;

   // Maps an exception kind to its Cause.ExcCode; ERET never reaches Cause
   function automatic logic [4:0] exc_code_of(input ExceptionType t);
      logic [4:0] code;
      code = EXC_CODE_INT;
      case (t)
         ExcAdEL:         code = EXC_CODE_ADEL;
         ExcAdES:         code = EXC_CODE_ADES;
         ExcSysCall:      code = EXC_CODE_SYS;
         ExcBreak:        code = EXC_CODE_BP;
         ExcReservedInst: code = EXC_CODE_RI;
         ExcOverflow:     code = EXC_CODE_OV;
         default:         code = EXC_CODE_INT;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// ---------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer. Count advances every second cycle through a toggle
// bit; TI is sticky-set whenever the post-update Count equals Compare and is
// cleared by ti_clr (driven on any MTC0 to Compare).
// Ports: clk, rst (async active-low), we/addr/wdata (MTC0 write port),
//        ti_clr, count, compare, ti.
// ---------------------------------------------------------------------------
module cp0_timer
   import cp0_regfile_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic        ti_clr,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic        toggle;
   logic        toggle_next;
   logic [31:0] count_next;
   logic [31:0] compare_next;
   logic        ti_next;

   // A Count write overrides the increment and restarts the half-rate phase;
   // the match is taken on the updated values, but a clear always wins.
   always_comb begin
      toggle_next  = ~toggle;
      count_next   = toggle ? count + 32'd1 : count;
      compare_next = compare;
      if (we && addr == CP0_COUNT) begin
         count_next  = wdata;
         toggle_next = 1'b0;
      end
      if (we && addr == CP0_COMPARE) begin
         compare_next = wdata;
      end
      ti_next = ti | (count_next == compare_next);
      if (ti_clr) begin
         ti_next = 1'b0;
      end
   end

   // Timer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         toggle  <= 1'b0;
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         toggle  <= toggle_next;
         count   <= count_next;
         compare <= compare_next;
         ti      <= ti_next;
      end
   end

endmodule

// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
// CP0 register file and exception responder. Absorbs committed exceptions and
// ERETs, updates EPC/Cause/Status/BadVAddr, serves MFC0 (combinational) and
// MTC0 (registered), and returns interrupt mask/enable state and the timer
// interrupt to commit.
// Ports: clk, rst (async active-low); exc_valid/exc_type/exc_pc/exc_is_ds/
//        exc_badvaddr (exception event); hw_int (Cause.IP[7:2] source);
//        mtc0_we/mtc0_addr/mtc0_wdata; mfc0_addr -> mfc0_rdata;
//        status_im, status_im_sw, cause_ip_sw, status_ie, status_exl, epc,
//        counter_int.
// ---------------------------------------------------------------------------
module cp0_regfile
   import cp0_regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         exc_valid,
   input  ExceptionType exc_type,
   input  logic [31:0]  exc_pc,
   input  logic         exc_is_ds,
   input  logic [31:0]  exc_badvaddr,
   input  logic [5:0]   hw_int,
   input  logic         mtc0_we,
   input  logic [4:0]   mtc0_addr,
   input  logic [31:0]  mtc0_wdata,
   input  logic [4:0]   mfc0_addr,
   output logic [31:0]  mfc0_rdata,
   output logic [5:0]   status_im,
   output logic [1:0]   status_im_sw,
   output logic [1:0]   cause_ip_sw,
   output logic         status_ie,
   output logic         status_exl,
   output logic [31:0]  epc,
   output logic         counter_int
);

   logic [31:0] status_q;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;
   logic        cause_bd;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw_q;
   logic [4:0]  cause_exc_code;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;
   logic        mtc0_eff;
   logic        compare_wr;
   logic [31:0] cause_val;

   // An exception in the same cycle swallows the MTC0, including timer writes
   assign mtc0_eff   = mtc0_we & ~exc_valid;
   assign compare_wr = mtc0_eff && (mtc0_addr == CP0_COMPARE);

   cp0_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .we      (mtc0_eff),
      .addr    (mtc0_addr),
      .wdata   (mtc0_wdata),
      .ti_clr  (compare_wr),
      .count   (count),
      .compare (compare),
      .ti      (ti)
   );

   // Exception/ERET/MTC0 register updates. A nested exception (EXL already
   // set) keeps the original EPC and BD so the outer handler can still return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q       <= STATUS_RESET;
         epc_q          <= '0;
         badvaddr_q     <= '0;
         cause_bd       <= 1'b0;
         cause_ip_hw    <= '0;
         cause_ip_sw_q  <= '0;
         cause_exc_code <= '0;
      end else begin
         cause_ip_hw <= hw_int;
         if (exc_valid) begin
            if (exc_type == ExcEret) begin
               status_q[1] <= 1'b0;
            end else begin
               if (!status_q[1]) begin
                  epc_q    <= exc_is_ds ? exc_pc - 32'd4 : exc_pc;
                  cause_bd <= exc_is_ds;
               end
               status_q[1]    <= 1'b1;
               cause_exc_code <= exc_code_of(exc_type);
               if (exc_type == ExcAdEL || exc_type == ExcAdES) begin
                  badvaddr_q <= exc_badvaddr;
               end
            end
         end else if (mtc0_we) begin
            case (mtc0_addr)
               CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
               CP0_CAUSE:  cause_ip_sw_q <= mtc0_wdata[9:8];
               CP0_EPC:    epc_q <= mtc0_wdata;
               default:    ;
            endcase
         end
      end
   end

   assign cause_val = {cause_bd, ti, 14'b0, cause_ip_hw, cause_ip_sw_q, 1'b0, cause_exc_code, 2'b0};

   // Unbypassed read mux: shows register state before any same-cycle write
   always_comb begin
      mfc0_rdata = '0;
      case (mfc0_addr)
         CP0_BADVADDR: mfc0_rdata = badvaddr_q;
         CP0_COUNT:    mfc0_rdata = count;
         CP0_COMPARE:  mfc0_rdata = compare;
         CP0_STATUS:   mfc0_rdata = status_q;
         CP0_CAUSE:    mfc0_rdata = cause_val;
         CP0_EPC:      mfc0_rdata = epc_q;
         CP0_PRID:     mfc0_rdata = PRID_VALUE;
         CP0_CONFIG:   mfc0_rdata = CONFIG_VALUE;
         default:      mfc0_rdata = '0;
      endcase
   end

   assign status_im    = status_q[15:10];
   assign status_im_sw = status_q[9:8];
   assign cause_ip_sw  = cause_ip_sw_q;
   assign status_ie    = status_q[0];
   assign status_exl   = status_q[1];
   assign epc          = epc_q;
   assign counter_int  = ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
// Directed scoreboard bench for cp0_regfile. Stimulus tasks push expected
// values into a queue while raising sample_en; an independent monitor pops
// and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_cp0_regfile;
   import cp0_regfile_pkg::*;

   localparam int SEL_RDATA  = 0;
   localparam int SEL_EPC    = 1;
   localparam int SEL_EXL    = 2;
   localparam int SEL_IE     = 3;
   localparam int SEL_TI     = 4;
   localparam int SEL_IPSW   = 5;
   localparam int SEL_IM     = 6;
   localparam int SEL_IMSW   = 7;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         exc_valid;
   ExceptionType exc_type;
   logic [31:0]  exc_pc;
   logic         exc_is_ds;
   logic [31:0]  exc_badvaddr;
   logic [5:0]   hw_int;
   logic         mtc0_we;
   logic [4:0]   mtc0_addr;
   logic [31:0]  mtc0_wdata;
   logic [4:0]   mfc0_addr;
   logic [31:0]  mfc0_rdata;
   logic [5:0]   status_im;
   logic [1:0]   status_im_sw;
   logic [1:0]   cause_ip_sw;
   logic         status_ie;
   logic         status_exl;
   logic [31:0]  epc;
   logic         counter_int;

   exp_t        sb[$];
   exp_t        cur;
   logic [31:0] act;
   logic        sample_en;
   int          checks;
   int          errors;

   cp0_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .exc_valid    (exc_valid),
      .exc_type     (exc_type),
      .exc_pc       (exc_pc),
      .exc_is_ds    (exc_is_ds),
      .exc_badvaddr (exc_badvaddr),
      .hw_int       (hw_int),
      .mtc0_we      (mtc0_we),
      .mtc0_addr    (mtc0_addr),
      .mtc0_wdata   (mtc0_wdata),
      .mfc0_addr    (mfc0_addr),
      .mfc0_rdata   (mfc0_rdata),
      .status_im    (status_im),
      .status_im_sw (status_im_sw),
      .cause_ip_sw  (cause_ip_sw),
      .status_ie    (status_ie),
      .status_exl   (status_exl),
      .epc          (epc),
      .counter_int  (counter_int)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] pick(input int sel);
      logic [31:0] v;
      v = '0;
      case (sel)
         SEL_RDATA: v = mfc0_rdata;
         SEL_EPC:   v = epc;
         SEL_EXL:   v = {31'b0, status_exl};
         SEL_IE:    v = {31'b0, status_ie};
         SEL_TI:    v = {31'b0, counter_int};
         SEL_IPSW:  v = {30'b0, cause_ip_sw};
         SEL_IM:    v = {26'b0, status_im};
         SEL_IMSW:  v = {30'b0, status_im_sw};
         default:   v = '0;
      endcase
      return v;
   endfunction

   // Monitor: compares the oldest expectation whenever the stimulus marks a
   // sample cycle, well away from the rising edge
   always @(negedge clk) begin
      if (sample_en) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: sample requested with no expectation");
         end else begin
            cur = sb.pop_front();
            act = pick(cur.sel);
            if (act !== cur.exp) begin
               errors++;
               $display("[TB] FAIL %s: got %h expected %h", cur.name, act, cur.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input int sel, input logic [4:0] addr,
                               input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      mfc0_addr = addr;
      sb.push_back(e);
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
   endtask

   task automatic apply_mtc0(input logic [4:0] addr, input logic [31:0] data);
      mtc0_we    = 1'b1;
      mtc0_addr  = addr;
      mtc0_wdata = data;
      tick();
      mtc0_we    = 1'b0;
   endtask

   task automatic apply_exc(input ExceptionType t, input logic [31:0] pc, input logic ds,
                            input logic [31:0] bva);
      exc_valid    = 1'b1;
      exc_type     = t;
      exc_pc       = pc;
      exc_is_ds    = ds;
      exc_badvaddr = bva;
      tick();
      exc_valid    = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      sample_en    = 1'b0;
      rst          = 1'b0;
      exc_valid    = 1'b0;
      exc_type     = ExcInterrupt;
      exc_pc       = '0;
      exc_is_ds    = 1'b0;
      exc_badvaddr = '0;
      hw_int       = '0;
      mtc0_we      = 1'b0;
      mtc0_addr    = '0;
      mtc0_wdata   = '0;
      mfc0_addr    = '0;
      tick();
      tick();

      // Reset state
      check_output("rst_status", SEL_RDATA, CP0_STATUS, 32'h0040_0000);
      check_output("rst_count",  SEL_RDATA, CP0_COUNT,  32'h0);
      check_output("rst_prid",   SEL_RDATA, CP0_PRID,   32'h0000_4220);
      check_output("rst_config", SEL_RDATA, CP0_CONFIG, 32'h8000_0000);
      check_output("rst_unimpl", SEL_RDATA, 5'd3,       32'h0);
      check_output("rst_epc",    SEL_EPC,   5'd0, 32'h0);
      check_output("rst_exl",    SEL_EXL,   5'd0, 32'h0);
      check_output("rst_ie",     SEL_IE,    5'd0, 32'h0);
      check_output("rst_ti",     SEL_TI,    5'd0, 32'h0);
      check_output("rst_ipsw",   SEL_IPSW,  5'd0, 32'h0);
      check_output("rst_im",     SEL_IM,    5'd0, 32'h0);
      check_output("rst_imsw",   SEL_IMSW,  5'd0, 32'h0);

      // Release: Count stays 0 for one edge, reaches 1 on the second
      rst = 1'b1;
      check_output("count_rel0", SEL_RDATA, CP0_COUNT, 32'h0);
      tick();
      check_output("count_rel1", SEL_RDATA, CP0_COUNT, 32'h1);

      // Park Compare far away (also clears the match taken at Count=0)
      apply_mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
      check_output("ti_cleared", SEL_TI, 5'd0, 32'h0);

      // Write masks
      apply_mtc0(CP0_STATUS, 32'hFFFF_FFFF);
      check_output("status_mask", SEL_RDATA, CP0_STATUS, 32'h0040_FF03);
      check_output("status_im",   SEL_IM,    5'd0, 32'h3F);
      check_output("status_imsw", SEL_IMSW,  5'd0, 32'h3);
      check_output("status_ie",   SEL_IE,    5'd0, 32'h1);
      check_output("status_exl",  SEL_EXL,   5'd0, 32'h1);
      apply_mtc0(CP0_STATUS, 32'h0);
      check_output("status_clr",  SEL_RDATA, CP0_STATUS, 32'h0040_0000);
      apply_mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      check_output("cause_mask",  SEL_RDATA, CP0_CAUSE, 32'h0000_0300);
      check_output("cause_ipsw",  SEL_IPSW,  5'd0, 32'h3);
      hw_int = 6'b100101;
      tick();
      check_output("cause_hwint", SEL_RDATA, CP0_CAUSE, 32'h0000_9700);
      hw_int = 6'b0;
      apply_mtc0(CP0_CAUSE, 32'h0);
      check_output("cause_clr",   SEL_RDATA, CP0_CAUSE, 32'h0);
      apply_mtc0(CP0_BADVADDR, 32'h0000_0055);
      check_output("badvaddr_ro", SEL_RDATA, CP0_BADVADDR, 32'h0);
      apply_mtc0(CP0_PRID, 32'h1);
      check_output("prid_ro",     SEL_RDATA, CP0_PRID, 32'h0000_4220);

      // Exception in a delay slot with EXL clear
      apply_exc(ExcOverflow, 32'hBFC0_1000, 1'b1, 32'h0);
      check_output("ov_epc",    SEL_EPC,   5'd0, 32'hBFC0_0FFC);
      check_output("ov_exl",    SEL_EXL,   5'd0, 32'h1);
      check_output("ov_cause",  SEL_RDATA, CP0_CAUSE,  32'h8000_0030);
      check_output("ov_epcreg", SEL_RDATA, CP0_EPC,    32'hBFC0_0FFC);
      check_output("ov_status", SEL_RDATA, CP0_STATUS, 32'h0040_0002);

      // Nested AdEL: EPC/BD preserved, BadVAddr and ExcCode updated
      apply_exc(ExcAdEL, 32'h0040_0100, 1'b0, 32'h1234_5679);
      check_output("adel_epc",   SEL_EPC,   5'd0, 32'hBFC0_0FFC);
      check_output("adel_bva",   SEL_RDATA, CP0_BADVADDR, 32'h1234_5679);
      check_output("adel_cause", SEL_RDATA, CP0_CAUSE,    32'h8000_0010);

      // ERET clears EXL only
      apply_exc(ExcEret, 32'h0, 1'b0, 32'hFFFF_FFFF);
      check_output("eret_exl",   SEL_EXL,   5'd0, 32'h0);
      check_output("eret_epc",   SEL_EPC,   5'd0, 32'hBFC0_0FFC);
      check_output("eret_cause", SEL_RDATA, CP0_CAUSE,    32'h8000_0010);
      check_output("eret_bva",   SEL_RDATA, CP0_BADVADDR, 32'h1234_5679);

      // Timer: Count restarts at 0, interrupt when it reaches Compare=5
      apply_mtc0(CP0_COUNT, 32'h0);
      apply_mtc0(CP0_COMPARE, 32'd5);
      check_output("tmr_ti_low", SEL_TI, 5'd0, 32'h0);
      for (int i = 0; i < 40; i++) begin
         if (counter_int) break;
         tick();
      end
      check_output("tmr_count5", SEL_RDATA, CP0_COUNT, 32'd5);
      check_output("tmr_ti_hi",  SEL_TI, 5'd0, 32'h1);
      apply_mtc0(CP0_COMPARE, 32'd100);
      check_output("tmr_ti_clr", SEL_TI, 5'd0, 32'h0);

      // Compare write coinciding with a match leaves TI clear
      apply_mtc0(CP0_COUNT, 32'd200);
      apply_mtc0(CP0_COMPARE, 32'd200);
      check_output("tmr_cmp_match", SEL_TI, 5'd0, 32'h0);

      // Count write wins and restarts the phase; 32-bit wrap
      apply_mtc0(CP0_COUNT, 32'hFFFF_FFFF);
      check_output("tmr_count_wr", SEL_RDATA, CP0_COUNT, 32'hFFFF_FFFF);
      tick();
      check_output("tmr_wrap",     SEL_RDATA, CP0_COUNT, 32'h0);

      // Exception and MTC0 EPC together: exception wins
      exc_valid    = 1'b1;
      exc_type     = ExcSysCall;
      exc_pc       = 32'h8000_0000;
      exc_is_ds    = 1'b0;
      exc_badvaddr = 32'h0;
      mtc0_we      = 1'b1;
      mtc0_addr    = CP0_EPC;
      mtc0_wdata   = 32'hDEAD_BEEF;
      tick();
      exc_valid    = 1'b0;
      mtc0_we      = 1'b0;
      check_output("col_epc",   SEL_EPC,   5'd0, 32'h8000_0000);
      check_output("col_cause", SEL_RDATA, CP0_CAUSE, 32'h0000_0020);
      check_output("col_exl",   SEL_EXL,   5'd0, 32'h1);

      // Asynchronous reset mid-operation
      rst = 1'b0;
      check_output("mid_rst_epc",    SEL_EPC,   5'd0, 32'h0);
      check_output("mid_rst_status", SEL_RDATA, CP0_STATUS, 32'h0040_0000);
      check_output("mid_rst_count",  SEL_RDATA, CP0_COUNT,  32'h0);
      rst = 1'b1;
      check_output("mid_rel_count0", SEL_RDATA, CP0_COUNT, 32'h0);
      tick();
      check_output("mid_rel_count1", SEL_RDATA, CP0_COUNT, 32'h1);

      tick();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
